pmem_arbiter: RTL and testbench

//  Sits directly downstream of the I-cache and D-cache controllers and owns the single physical-memory port.

---
 rtl/lc3b_types.sv | 22 ++
 rtl/pmem_arbiter_datapath.sv | 40 ++++
 rtl/pmem_arbiter.sv | 136 +++++++++++++
 tb/tb_pmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the memory subsystem: cache line vector and
// arbiter ownership encoding used by the pmem arbiter.
package lc3b_types;

  localparam int PMEM_LINE_W = 128;
  localparam int PMEM_ADDR_W = 16;
  localparam int PMEM_CNT_W  = 16;

  typedef logic [PMEM_LINE_W-1:0] lc3b_cache_line;

  typedef enum logic {
    ARB_ICACHE = 1'b0,
    ARB_DCACHE = 1'b1
  } lc3b_arb_owner;

  function automatic lc3b_arb_owner arb_other(
    input lc3b_arb_owner o
  );
    return (o == ARB_ICACHE) ? ARB_DCACHE : ARB_ICACHE;
  endfunction

endpackage

// File: rtl/pmem_arbiter_datapath.sv
// Owner-selected address/wdata mux toward pmem and rdata fan-out.
// Ports: active_i/owner_i select, client addr/wdata in, pmem addr/wdata out.
module pmem_arbiter_datapath
  import lc3b_types::*;
#(
  parameter int LINE_W = PMEM_LINE_W,
  parameter int ADDR_W = PMEM_ADDR_W
) (
  input  logic              active_i,
  input  lc3b_arb_owner     owner_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  input  logic [LINE_W-1:0] pmem_rdata_i,
  output logic [ADDR_W-1:0] pmem_addr_o,
  output logic [LINE_W-1:0] pmem_wdata_o,
  output logic [LINE_W-1:0] i_rdata_o,
  output logic [LINE_W-1:0] d_rdata_o
);

  logic [ADDR_W-1:0] addr_sel;

  always_comb begin
    addr_sel     = '0;
    pmem_wdata_o = '0;
    if (active_i) begin
      addr_sel = (owner_i == ARB_ICACHE) ? i_addr_i : d_addr_i;
      if (owner_i == ARB_DCACHE)
        pmem_wdata_o = d_wdata_i;
    end
  end

  // Lines are 16 bytes, so the byte offset is always zero.
  assign pmem_addr_o = {addr_sel[ADDR_W-1:4], 4'b0000};

  // Broadcast unregistered; each client's resp qualifies its copy.
  assign i_rdata_o = pmem_rdata_i;
  assign d_rdata_o = pmem_rdata_i;

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line transfers onto one pmem port,
// round-robin on ties, locked to the owner until pmem_resp.
// Ports: I/D cache request sides, pmem master side, conflict_count.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_W = PMEM_LINE_W,
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int CNT_W  = PMEM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  arb_state_e       state_q, state_d;
  lc3b_arb_owner    owner_q, owner_d;
  lc3b_arb_owner    last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic i_req, d_req, owner_req, other_req;

  assign i_req     = i_pmem_read;
  assign d_req     = d_pmem_read | d_pmem_write;
  assign owner_req = (owner_q == ARB_ICACHE) ? i_req : d_req;
  assign other_req = (owner_q == ARB_ICACHE) ? d_req : i_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= ARB_DCACHE;
      last_q  <= ARB_DCACHE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req && d_req) begin
          owner_d = arb_other(last_q);
          state_d = ST_SERVE;
        end else if (i_req) begin
          owner_d = ARB_ICACHE;
          state_d = ST_SERVE;
        end else if (d_req) begin
          owner_d = ARB_DCACHE;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (!owner_req) begin
          // Owner aborted: drop without a resp.
          state_d = ST_IDLE;
        end else begin
          if (owner_q == ARB_ICACHE) begin
            pmem_read = 1'b1;
          end else begin
            // Write-back wins over a simultaneous fill.
            pmem_write = d_pmem_write;
            pmem_read  = ~d_pmem_write;
          end
          if (pmem_resp) begin
            i_pmem_resp = (owner_q == ARB_ICACHE);
            d_pmem_resp = (owner_q == ARB_DCACHE);
            last_d      = owner_q;
            state_d     = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_IDLE && other_req && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  assign conflict_count = cnt_q;

  pmem_arbiter_datapath #(
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W)
  ) u_dp (
    .active_i     (state_q == ST_SERVE),
    .owner_i      (owner_q),
    .i_addr_i     (i_pmem_address),
    .d_addr_i     (d_pmem_address),
    .d_wdata_i    (d_pmem_wdata),
    .pmem_rdata_i (pmem_rdata),
    .pmem_addr_o  (pmem_address),
    .pmem_wdata_o (pmem_wdata),
    .i_rdata_o    (i_pmem_rdata),
    .d_rdata_o    (d_pmem_rdata)
  );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter.
// Ports: none; drives DUT with hand-computed vectors.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_pmem_read = 1'b0;
  logic [15:0]  i_pmem_address = '0;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [15:0]  d_pmem_address = '0;
  logic [127:0] d_pmem_wdata = '0;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [15:0]  conflict_count;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [127:0] RD_A5 = {16{8'hA5}};
  localparam logic [127:0] W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] W2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
  localparam logic [127:0] W3 = 128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .conflict_count (conflict_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start of a cycle: 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".rd"}, 128'(pmem_read), 128'(0));
    chk({tag, ".wr"}, 128'(pmem_write), 128'(0));
    chk({tag, ".iresp"}, 128'(i_pmem_resp), 128'(0));
    chk({tag, ".dresp"}, 128'(d_pmem_resp), 128'(0));
  endtask

  initial begin
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    idle_chk("rst");
    chk("rst.addr", 128'(pmem_address), 128'(0));
    chk("rst.wdata", pmem_wdata, 128'(0));
    chk("rst.cnt", 128'(conflict_count), 128'(0));

    // Test 1: reset during a D write-back with pmem_resp pending.
    cyc();
    d_pmem_write = 1'b1;
    d_pmem_address = 16'h4567;
    d_pmem_wdata = W1;
    #1;
    chk("t1.grantcyc.wr", 128'(pmem_write), 128'(0));
    cyc();
    #1;
    chk("t1.serve.wr", 128'(pmem_write), 128'(1));
    chk("t1.serve.addr", 128'(pmem_address), 128'h4560);
    chk("t1.serve.wdata", pmem_wdata, W1);
    pmem_resp = 1'b1;
    reset = 1'b1;
    #1;
    chk("t1.rst.wr", 128'(pmem_write), 128'(0));
    chk("t1.rst.dresp", 128'(d_pmem_resp), 128'(0));
    cyc();
    d_pmem_write = 1'b0;
    pmem_resp = 1'b0;
    reset = 1'b0;
    #1;
    idle_chk("t1.after");
    cyc();
    #1;
    idle_chk("t1.idle");

    // Test 2: I-only read, resp in cycle 5.
    cyc();
    i_pmem_read = 1'b1;
    i_pmem_address = 16'h1230;
    #1;
    chk("t2.c0.rd", 128'(pmem_read), 128'(0));
    for (int c = 1; c <= 4; c++) begin
      cyc();
      #1;
      chk("t2.wait.rd", 128'(pmem_read), 128'(1));
      chk("t2.wait.iresp", 128'(i_pmem_resp), 128'(0));
    end
    chk("t2.addr", 128'(pmem_address), 128'h1230);
    cyc();
    pmem_resp = 1'b1;
    pmem_rdata = RD_A5;
    #1;
    chk("t2.c5.iresp", 128'(i_pmem_resp), 128'(1));
    chk("t2.c5.dresp", 128'(d_pmem_resp), 128'(0));
    chk("t2.c5.irdata", i_pmem_rdata, RD_A5);
    chk("t2.c5.drdata", d_pmem_rdata, RD_A5);
    // RELEASE: stale request and stale resp both held.
    cyc();
    #1;
    chk("t2.rel.rd", 128'(pmem_read), 128'(0));
    chk("t2.rel.iresp", 128'(i_pmem_resp), 128'(0));
    cyc();
    i_pmem_read = 1'b0;
    pmem_resp = 1'b0;
    #1;
    idle_chk("t2.idle");
    chk("t2.cnt", 128'(conflict_count), 128'(0));

    // Re-establish last_owner = DCACHE.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    cyc();

    // Tests 3/4: I and D collide; I re-requests right after its resp.
    i_pmem_read = 1'b1;
    i_pmem_address = 16'h1230;
    d_pmem_write = 1'b1;
    d_pmem_address = 16'h4560;
    d_pmem_wdata = W2;
    #1;
    idle_chk("t3.c0");
    cyc();
    #1;
    chk("t3.c1.rd", 128'(pmem_read), 128'(1));
    chk("t3.c1.wr", 128'(pmem_write), 128'(0));
    chk("t3.c1.addr", 128'(pmem_address), 128'h1230);
    chk("t3.c1.cnt", 128'(conflict_count), 128'(0));
    cyc();
    #1;
    chk("t3.c2.cnt", 128'(conflict_count), 128'(1));
    cyc();
    pmem_resp = 1'b1;
    #1;
    chk("t3.c3.iresp", 128'(i_pmem_resp), 128'(1));
    chk("t3.c3.dresp", 128'(d_pmem_resp), 128'(0));
    cyc();
    pmem_resp = 1'b0;
    #1;
    idle_chk("t3.c4rel");
    chk("t3.c4.cnt", 128'(conflict_count), 128'(3));
    cyc();
    #1;
    idle_chk("t4.c5idle");
    cyc();
    #1;
    chk("t4.c6.wr", 128'(pmem_write), 128'(1));
    chk("t4.c6.rd", 128'(pmem_read), 128'(0));
    chk("t4.c6.addr", 128'(pmem_address), 128'h4560);
    chk("t4.c6.wdata", pmem_wdata, W2);
    chk("t3.c6.cnt", 128'(conflict_count), 128'(4));
    cyc();
    pmem_resp = 1'b1;
    #1;
    chk("t4.c7.dresp", 128'(d_pmem_resp), 128'(1));
    chk("t4.c7.iresp", 128'(i_pmem_resp), 128'(0));
    chk("t4.c7.cnt", 128'(conflict_count), 128'(5));
    cyc();
    pmem_resp = 1'b0;
    d_pmem_write = 1'b0;
    #1;
    idle_chk("t4.c8rel");
    chk("t4.c8.cnt", 128'(conflict_count), 128'(6));
    cyc();
    #1;
    idle_chk("t4.c9idle");
    chk("t4.c9.cnt", 128'(conflict_count), 128'(7));
    cyc();
    #1;
    chk("t4.c10.rd", 128'(pmem_read), 128'(1));
    // Abort: I drops its request before any resp.
    i_pmem_read = 1'b0;
    #1;
    chk("abort.rd", 128'(pmem_read), 128'(0));
    cyc();
    #1;
    idle_chk("abort.idle");
    chk("abort.cnt", 128'(conflict_count), 128'(7));

    // Test 5: D read+write together.
    cyc();
    d_pmem_read = 1'b1;
    d_pmem_write = 1'b1;
    d_pmem_address = 16'h7777;
    d_pmem_wdata = W3;
    cyc();
    #1;
    chk("t5.wr", 128'(pmem_write), 128'(1));
    chk("t5.rd", 128'(pmem_read), 128'(0));
    chk("t5.addr", 128'(pmem_address), 128'h7770);
    chk("t5.wdata", pmem_wdata, W3);
    pmem_resp = 1'b1;
    #1;
    chk("t5.dresp", 128'(d_pmem_resp), 128'(1));
    cyc();
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    pmem_resp = 1'b0;
    cyc();

    // Test 6: pmem_resp while IDLE is never forwarded.
    pmem_resp = 1'b1;
    #1;
    idle_chk("t6.idleresp");
    cyc();
    pmem_resp = 1'b0;

    // Saturation: hold contention with no resp.
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    #1;
    chk("t6.cnt0", 128'(conflict_count), 128'(7));
    repeat (70000) @(posedge clk);
    #2;
    chk("t6.sat", 128'(conflict_count), 128'hFFFF);
    repeat (3) cyc();
    chk("t6.sat2", 128'(conflict_count), 128'hFFFF);
    reset = 1'b1;
    #1;
    chk("t6.rst.cnt", 128'(conflict_count), 128'(0));
    idle_chk("t6.rst");
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
